// File: rtl/pipe_ctrl_sequencer_pkg.sv
// Purpose: shared definitions for the pipeline control sequencer:
//   control-bundle widths and bit positions, PC-select and forwarding codes,
//   sequencer state encoding, per-stage pipeline register payloads, and the
//   forwarding compare helper.
// Ports: none (package).
package pipe_ctrl_sequencer_pkg;

   localparam int unsigned EX_W  = 4;   // {RegDst, ALUOp[1:0], ALUSrc}
   localparam int unsigned MEM_W = 3;   // {MemRead, MemWrite, MemtoReg}
   localparam int unsigned WB_W  = 2;   // {RegWrite, MemtoReg}
   localparam int unsigned REG_W = 5;

   localparam int unsigned EX_REGDST   = 3;
   localparam int unsigned MEM_MEMREAD = 2;
   localparam int unsigned MEM_MEMWRT  = 1;
   localparam int unsigned WB_REGWRITE = 1;

   localparam logic [1:0] PC_SEL_PC4 = 2'b00;
   localparam logic [1:0] PC_SEL_BR  = 2'b01;
   localparam logic [1:0] PC_SEL_J   = 2'b10;
   localparam logic [1:0] PC_SEL_JR  = 2'b11;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic [1:0] {
      ST_RUN    = 2'b00,
      ST_LSTALL = 2'b01,
      ST_MWAIT  = 2'b10
   } state_t;

   // ID/EX register payload
   typedef struct packed {
      logic [EX_W-1:0]  ex;
      logic [MEM_W-1:0] mem;
      logic [WB_W-1:0]  wb;
      logic             branch;
      logic [REG_W-1:0] rs;
      logic [REG_W-1:0] rt;
      logic [REG_W-1:0] dst;
   } idex_t;

   // EX/MEM register payload
   typedef struct packed {
      logic [MEM_W-1:0] mem;
      logic [WB_W-1:0]  wb;
      logic [REG_W-1:0] dst;
   } exmem_t;

   // MEM/WB register payload
   typedef struct packed {
      logic [WB_W-1:0]  wb;
      logic [REG_W-1:0] dst;
   } memwb_t;

   // A later stage supplies an operand when it writes a non-zero matching register
   function automatic logic fwd_hit(input logic             regwrite,
                                    input logic [REG_W-1:0] dst,
                                    input logic [REG_W-1:0] src);
      return regwrite && (dst != '0) && (dst == src);
   endfunction

endpackage

// File: rtl/pipe_ctrl_sequencer_fwd_unit.sv
// Purpose: combinational ALU operand forwarding select for the instruction in EX.
// Ports:
//   i_ex_rs / i_ex_rt         source registers of the instruction in EX
//   i_exmem_regwrite/_dst     EX/MEM write-back intent and destination
//   i_memwb_regwrite/_dst     MEM/WB write-back intent and destination
//   o_fwd_a / o_fwd_b         operand selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
module pipe_ctrl_sequencer_fwd_unit
   import pipe_ctrl_sequencer_pkg::*;
(
   input  logic [REG_W-1:0] i_ex_rs,
   input  logic [REG_W-1:0] i_ex_rt,
   input  logic             i_exmem_regwrite,
   input  logic [REG_W-1:0] i_exmem_dst,
   input  logic             i_memwb_regwrite,
   input  logic [REG_W-1:0] i_memwb_dst,
   output logic [1:0]       o_fwd_a,
   output logic [1:0]       o_fwd_b
);

   // EX/MEM holds the younger result, so it is checked first
   always_comb begin
      o_fwd_a = FWD_RF;
      o_fwd_b = FWD_RF;
      if (fwd_hit(i_exmem_regwrite, i_exmem_dst, i_ex_rs))
         o_fwd_a = FWD_EXMEM;
      else if (fwd_hit(i_memwb_regwrite, i_memwb_dst, i_ex_rs))
         o_fwd_a = FWD_MEMWB;
      if (fwd_hit(i_exmem_regwrite, i_exmem_dst, i_ex_rt))
         o_fwd_b = FWD_EXMEM;
      else if (fwd_hit(i_memwb_regwrite, i_memwb_dst, i_ex_rt))
         o_fwd_b = FWD_MEMWB;
   end

endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// Purpose: carries decoded EX/MEM/WB control bundles through the ID/EX, EX/MEM
//   and MEM/WB registers of a 5-stage MIPS pipeline, resolves load-use stalls,
//   branch/jump redirects and data-memory wait states, and drives PC/IF-ID
//   enables, PC select and operand forwarding selects.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_ex/id_mem/id_wb             control bundles from decode
//   id_branch/id_jump/id_jr        control-flow decode flags
//   id_rs/id_rt/id_rd              register fields of the instruction in ID
//   ex_zero                        ALU zero flag of the instruction in EX
//   mem_ready                      data memory access completes this cycle
//   pc_write/ifid_write/ifid_flush PC and IF/ID controls (combinational)
//   pc_sel                         next-PC source (combinational)
//   ex_ctrl/mem_ctrl/wb_ctrl       registered stage control bundles
//   fwd_a/fwd_b                    forwarding selects (combinational)
//   mem_err                        sticky memory timeout flag
module pipe_ctrl_sequencer
   import pipe_ctrl_sequencer_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [EX_W-1:0]  id_ex,
   input  logic [MEM_W-1:0] id_mem,
   input  logic [WB_W-1:0]  id_wb,
   input  logic             id_branch,
   input  logic             id_jump,
   input  logic             id_jr,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic [REG_W-1:0] id_rd,
   input  logic             ex_zero,
   input  logic             mem_ready,
   output logic             pc_write,
   output logic             ifid_write,
   output logic             ifid_flush,
   output logic [1:0]       pc_sel,
   output logic [EX_W-1:0]  ex_ctrl,
   output logic [MEM_W-1:0] mem_ctrl,
   output logic [WB_W-1:0]  wb_ctrl,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err
);

   localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t           r_state;
   state_t           w_state_nxt;
   idex_t            r_idex;
   idex_t            w_idex_nxt;
   exmem_t           r_exmem;
   exmem_t           w_exmem_nxt;
   memwb_t           r_memwb;
   memwb_t           w_memwb_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             r_mem_err;
   logic             w_mem_err_nxt;

   idex_t            w_id_bundle;
   logic             w_mem_hold;
   logic             w_br_taken;
   logic             w_load_use;
   logic             w_pc_write;
   logic             w_ifid_write;
   logic             w_ifid_flush;
   logic [1:0]       w_pc_sel;

   // Decode-side payload for ID/EX; destination resolved here from RegDst
   always_comb begin
      w_id_bundle        = '0;
      w_id_bundle.ex     = id_ex;
      w_id_bundle.mem    = id_mem;
      w_id_bundle.wb     = id_wb;
      w_id_bundle.branch = id_branch;
      w_id_bundle.rs     = id_rs;
      w_id_bundle.rt     = id_rt;
      w_id_bundle.dst    = id_ex[EX_REGDST] ? id_rd : id_rt;
   end

   // A memory op in EX/MEM that has not completed freezes the whole pipe
   assign w_mem_hold = (r_exmem.mem[MEM_MEMREAD] | r_exmem.mem[MEM_MEMWRT]) & ~mem_ready;
   assign w_br_taken = r_idex.branch & ex_zero;
   assign w_load_use = r_idex.mem[MEM_MEMREAD] && (r_idex.dst != '0) &&
                       ((r_idex.dst == id_rs) || (r_idex.dst == id_rt));

   // State and pipeline registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_RUN;
         r_idex    <= '0;
         r_exmem   <= '0;
         r_memwb   <= '0;
         r_cnt     <= '0;
         r_mem_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_idex    <= w_idex_nxt;
         r_exmem   <= w_exmem_nxt;
         r_memwb   <= w_memwb_nxt;
         r_cnt     <= w_cnt_nxt;
         r_mem_err <= w_mem_err_nxt;
      end
   end

   // Next state, pipeline advance and hazard controls
   always_comb begin
      w_state_nxt   = r_state;
      w_idex_nxt    = r_idex;
      w_exmem_nxt   = r_exmem;
      w_memwb_nxt   = r_memwb;
      w_cnt_nxt     = r_cnt;
      w_mem_err_nxt = r_mem_err;
      w_pc_write    = 1'b0;
      w_ifid_write  = 1'b0;
      w_ifid_flush  = 1'b0;
      w_pc_sel      = PC_SEL_PC4;

      if (w_mem_hold) begin
         // Wait cycles are counted only once in MWAIT; saturate at the limit
         w_state_nxt = ST_MWAIT;
         if (r_state == ST_MWAIT && r_cnt != CNT_W'(MEM_TIMEOUT))
            w_cnt_nxt = r_cnt + CNT_W'(1);
      end else begin
         w_state_nxt     = ST_RUN;
         w_cnt_nxt       = '0;
         w_pc_write      = 1'b1;
         w_ifid_write    = 1'b1;
         w_memwb_nxt.wb  = r_exmem.wb;
         w_memwb_nxt.dst = r_exmem.dst;
         w_exmem_nxt.mem = r_idex.mem;
         w_exmem_nxt.wb  = r_idex.wb;
         w_exmem_nxt.dst = r_idex.dst;
         if (w_br_taken) begin
            w_pc_sel     = PC_SEL_BR;
            w_ifid_flush = 1'b1;
            w_idex_nxt   = '0;
         end else if (w_load_use) begin
            // Hold PC and IF/ID one cycle while a bubble separates load and user
            w_pc_write   = 1'b0;
            w_ifid_write = 1'b0;
            w_idex_nxt   = '0;
            w_state_nxt  = ST_LSTALL;
         end else begin
            w_idex_nxt = w_id_bundle;
            if (id_jump) begin
               w_pc_sel     = id_jr ? PC_SEL_JR : PC_SEL_J;
               w_ifid_flush = 1'b1;
            end
         end
      end

      if (r_state == ST_MWAIT && r_cnt == CNT_W'(MEM_TIMEOUT))
         w_mem_err_nxt = 1'b1;

      // Reset keeps the front end parked on a NOP
      if (rst) begin
         w_pc_write   = 1'b0;
         w_ifid_write = 1'b0;
         w_ifid_flush = 1'b1;
         w_pc_sel     = PC_SEL_PC4;
      end
   end

   pipe_ctrl_sequencer_fwd_unit u_fwd (
      .i_ex_rs          (r_idex.rs),
      .i_ex_rt          (r_idex.rt),
      .i_exmem_regwrite (r_exmem.wb[WB_REGWRITE]),
      .i_exmem_dst      (r_exmem.dst),
      .i_memwb_regwrite (r_memwb.wb[WB_REGWRITE]),
      .i_memwb_dst      (r_memwb.dst),
      .o_fwd_a          (fwd_a),
      .o_fwd_b          (fwd_b)
   );

   assign pc_write   = w_pc_write;
   assign ifid_write = w_ifid_write;
   assign ifid_flush = w_ifid_flush;
   assign pc_sel     = w_pc_sel;
   assign ex_ctrl    = r_idex.ex;
   assign mem_ctrl   = r_exmem.mem;
   assign wb_ctrl    = r_memwb.wb;
   assign mem_err    = r_mem_err;

endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// Purpose: directed self-checking bench for pipe_ctrl_sequencer.
// Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
module tb_pipe_ctrl_sequencer;
   import pipe_ctrl_sequencer_pkg::*;

   logic       clk;
   logic       rst;
   logic [3:0] id_ex;
   logic [2:0] id_mem;
   logic [1:0] id_wb;
   logic       id_branch;
   logic       id_jump;
   logic       id_jr;
   logic [4:0] id_rs;
   logic [4:0] id_rt;
   logic [4:0] id_rd;
   logic       ex_zero;
   logic       mem_ready;
   logic       pc_write;
   logic       ifid_write;
   logic       ifid_flush;
   logic [1:0] pc_sel;
   logic [3:0] ex_ctrl;
   logic [2:0] mem_ctrl;
   logic [1:0] wb_ctrl;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       mem_err;

   int n_checks = 0;
   int n_fail   = 0;

   pipe_ctrl_sequencer #(.MEM_TIMEOUT(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .id_ex      (id_ex),
      .id_mem     (id_mem),
      .id_wb      (id_wb),
      .id_branch  (id_branch),
      .id_jump    (id_jump),
      .id_jr      (id_jr),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rd      (id_rd),
      .ex_zero    (ex_zero),
      .mem_ready  (mem_ready),
      .pc_write   (pc_write),
      .ifid_write (ifid_write),
      .ifid_flush (ifid_flush),
      .pc_sel     (pc_sel),
      .ex_ctrl    (ex_ctrl),
      .mem_ctrl   (mem_ctrl),
      .wb_ctrl    (wb_ctrl),
      .fwd_a      (fwd_a),
      .fwd_b      (fwd_b),
      .mem_err    (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_id(input logic [3:0] ex, input logic [2:0] mem, input logic [1:0] wb,
                           input logic br, input logic j, input logic jr,
                           input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      id_ex = ex; id_mem = mem; id_wb = wb;
      id_branch = br; id_jump = j; id_jr = jr;
      id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   task automatic drive_nop();
      drive_id(4'b0000, 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
   endtask

   task automatic drain();
      for (int i = 0; i < 3; i++) begin
         step();
         drive_nop();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ex_zero = 1'b0; mem_ready = 1'b1;
      drive_nop();
      #2;
      n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rst_pc_write got=%b exp=0", pc_write); end
      n_checks++; if (ifid_write !== 1'b0) begin n_fail++; $display("FAIL rst_ifid_write got=%b exp=0", ifid_write); end
      n_checks++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL rst_ifid_flush got=%b exp=1", ifid_flush); end
      n_checks++; if (pc_sel !== 2'b00) begin n_fail++; $display("FAIL rst_pc_sel got=%b exp=00", pc_sel); end
      step();
      step();
      rst = 1'b0;
      #1;
      n_checks++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 9'd0) begin n_fail++; $display("FAIL rst_bundles got=%b_%b_%b exp=0", ex_ctrl, mem_ctrl, wb_ctrl); end
      n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL rst_fwd got=%b/%b exp=00/00", fwd_a, fwd_b); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rst_mem_err got=%b exp=0", mem_err); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rst_release_pc_write got=%b exp=1", pc_write); end
   endtask

   // lw $2,0($1); add $3,$2,$4
   task automatic test_load_use();
      step(); drive_id(4'b0001, 3'b101, 2'b11, 1'b0, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); #1;
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_lw_pc_write got=%b exp=1", pc_write); end
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 5'd4, 5'd3); #1;
      n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL lu_stall_pc_write got=%b exp=0", pc_write); end
      n_checks++; if (ifid_write !== 1'b0) begin n_fail++; $display("FAIL lu_stall_ifid_write got=%b exp=0", ifid_write); end
      n_checks++; if (ifid_flush !== 1'b0) begin n_fail++; $display("FAIL lu_stall_flush got=%b exp=0", ifid_flush); end
      n_checks++; if (ex_ctrl !== 4'b0001) begin n_fail++; $display("FAIL lu_lw_in_ex got=%b exp=0001", ex_ctrl); end
      step(); #1;
      n_checks++; if (ex_ctrl !== 4'b0000) begin n_fail++; $display("FAIL lu_bubble got=%b exp=0000", ex_ctrl); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL lu_resume_pc_write got=%b exp=1", pc_write); end
      n_checks++; if (mem_ctrl !== 3'b101) begin n_fail++; $display("FAIL lu_lw_in_mem got=%b exp=101", mem_ctrl); end
      step(); drive_nop(); #1;
      n_checks++; if (fwd_a !== 2'b01) begin n_fail++; $display("FAIL lu_fwd_a got=%b exp=01", fwd_a); end
      n_checks++; if (fwd_b !== 2'b00) begin n_fail++; $display("FAIL lu_fwd_b got=%b exp=00", fwd_b); end
      n_checks++; if (ex_ctrl !== 4'b1100) begin n_fail++; $display("FAIL lu_add_in_ex got=%b exp=1100", ex_ctrl); end
      n_checks++; if (wb_ctrl !== 2'b11) begin n_fail++; $display("FAIL lu_lw_in_wb got=%b exp=11", wb_ctrl); end
      drain();
   endtask

   task automatic test_forward();
      // add $2,$1,$3; sub $5,$2,$2
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 5'd2); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 5'd5); #1;
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL fw_no_stall got=%b exp=1", pc_write); end
      step(); drive_nop(); #1;
      n_checks++; if ({fwd_a, fwd_b} !== 4'b1010) begin n_fail++; $display("FAIL fw_exmem got=%b/%b exp=10/10", fwd_a, fwd_b); end
      drain();
      // add $2; add $2; sub $5,$2,$0; sub $6,$2,$2
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 5'd2); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd6, 5'd7, 5'd2); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 5'd0, 5'd5); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd2, 5'd2, 5'd6); #1;
      n_checks++; if ({fwd_a, fwd_b} !== 4'b1000) begin n_fail++; $display("FAIL fw_priority got=%b/%b exp=10/00", fwd_a, fwd_b); end
      step(); drive_nop(); #1;
      n_checks++; if ({fwd_a, fwd_b} !== 4'b0101) begin n_fail++; $display("FAIL fw_memwb got=%b/%b exp=01/01", fwd_a, fwd_b); end
      drain();
      // add $0,$1,$3; sub $5,$0,$0
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd1, 5'd3, 5'd0); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd5); #1;
      step(); drive_nop(); #1;
      n_checks++; if ({fwd_a, fwd_b} !== 4'b0000) begin n_fail++; $display("FAIL fw_zero_reg got=%b/%b exp=00/00", fwd_a, fwd_b); end
      drain();
   endtask

   task automatic test_branch();
      // taken
      step(); drive_id(4'b0010, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd7); ex_zero = 1'b1; #1;
      n_checks++; if (pc_sel !== 2'b01) begin n_fail++; $display("FAIL br_taken_pc_sel got=%b exp=01", pc_sel); end
      n_checks++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL br_taken_flush got=%b exp=1", ifid_flush); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL br_taken_pc_write got=%b exp=1", pc_write); end
      step(); ex_zero = 1'b0; drive_nop(); #1;
      n_checks++; if (ex_ctrl !== 4'b0000) begin n_fail++; $display("FAIL br_taken_bubble got=%b exp=0000", ex_ctrl); end
      n_checks++; if (pc_sel !== 2'b00) begin n_fail++; $display("FAIL br_after_pc_sel got=%b exp=00", pc_sel); end
      // not taken
      step(); drive_id(4'b0010, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd3, 5'd4, 5'd7); #1;
      n_checks++; if (pc_sel !== 2'b00) begin n_fail++; $display("FAIL br_nt_pc_sel got=%b exp=00", pc_sel); end
      n_checks++; if (ifid_flush !== 1'b0) begin n_fail++; $display("FAIL br_nt_flush got=%b exp=0", ifid_flush); end
      step(); drive_nop(); #1;
      n_checks++; if (ex_ctrl !== 4'b1100) begin n_fail++; $display("FAIL br_nt_next got=%b exp=1100", ex_ctrl); end
      // taken branch in EX outranks a jump in ID
      step(); drive_id(4'b0010, 3'b000, 2'b00, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 5'd0); #1;
      step(); drive_id(4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); ex_zero = 1'b1; #1;
      n_checks++; if (pc_sel !== 2'b01) begin n_fail++; $display("FAIL br_over_jump got=%b exp=01", pc_sel); end
      step(); ex_zero = 1'b0; drive_nop();
      drain();
   endtask

   task automatic test_jump();
      step(); drive_id(4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0); #1;
      n_checks++; if (pc_sel !== 2'b10) begin n_fail++; $display("FAIL j_pc_sel got=%b exp=10", pc_sel); end
      n_checks++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL j_flush got=%b exp=1", ifid_flush); end
      step(); drive_id(4'b0000, 3'b000, 2'b00, 1'b0, 1'b1, 1'b1, 5'd31, 5'd0, 5'd0); #1;
      n_checks++; if (pc_sel !== 2'b11) begin n_fail++; $display("FAIL jr_pc_sel got=%b exp=11", pc_sel); end
      n_checks++; if (ifid_flush !== 1'b1) begin n_fail++; $display("FAIL jr_flush got=%b exp=1", ifid_flush); end
      step(); drive_nop(); #1;
      n_checks++; if ({pc_sel, ifid_flush} !== 3'b000) begin n_fail++; $display("FAIL j_after got=%b/%b exp=00/0", pc_sel, ifid_flush); end
      drain();
   endtask

   // sw held 3 cycles by mem_ready=0
   task automatic test_mem_wait();
      step(); drive_id(4'b0001, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd6, 5'd7, 5'd3); #1;
      step(); drive_id(4'b0101, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd9, 5'd10, 5'd8); mem_ready = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         if (i > 0) begin step(); #1; end
         n_checks++; if ({ex_ctrl, mem_ctrl} !== 7'b1100_010) begin n_fail++; $display("FAIL mw_frozen%0d got=%b_%b exp=1100_010", i, ex_ctrl, mem_ctrl); end
         n_checks++; if ({pc_write, ifid_write, ifid_flush} !== 3'b000) begin n_fail++; $display("FAIL mw_hold%0d got=%b%b%b exp=000", i, pc_write, ifid_write, ifid_flush); end
      end
      step(); mem_ready = 1'b1; #1;
      n_checks++; if (mem_ctrl !== 3'b010) begin n_fail++; $display("FAIL mw_last_frozen got=%b exp=010", mem_ctrl); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL mw_release got=%b exp=1", pc_write); end
      step(); drive_nop(); #1;
      n_checks++; if ({ex_ctrl, mem_ctrl} !== 7'b0101_000) begin n_fail++; $display("FAIL mw_advance got=%b_%b exp=0101_000", ex_ctrl, mem_ctrl); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL mw_no_err got=%b exp=0", mem_err); end
      drain();
   endtask

   task automatic test_timeout(input int n_low, input logic exp_err);
      step(); drive_id(4'b0001, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0); #1;
      step(); drive_nop(); #1;
      step(); mem_ready = 1'b0;
      for (int i = 1; i < n_low; i++) step();
      step(); mem_ready = 1'b1; #1;
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL to%0d_release got=%b exp=1", n_low, pc_write); end
      step(); step(); #1;
      n_checks++; if (mem_err !== exp_err) begin n_fail++; $display("FAIL to%0d_mem_err got=%b exp=%b", n_low, mem_err, exp_err); end
      drain();
   endtask

   task automatic test_reset_in_mwait();
      step(); drive_id(4'b0001, 3'b010, 2'b00, 1'b0, 1'b0, 1'b0, 5'd1, 5'd5, 5'd0); #1;
      step(); drive_id(4'b1100, 3'b000, 2'b10, 1'b0, 1'b0, 1'b0, 5'd6, 5'd7, 5'd3); #1;
      step(); mem_ready = 1'b0; #1;
      n_checks++; if (pc_write !== 1'b0) begin n_fail++; $display("FAIL rw_hold got=%b exp=0", pc_write); end
      step(); #1;
      step(); rst = 1'b1; #1;
      n_checks++; if ({pc_write, ifid_write, ifid_flush, pc_sel} !== 5'b00100) begin n_fail++; $display("FAIL rw_rst_ctrl got=%b%b%b%b exp=00100", pc_write, ifid_write, ifid_flush, pc_sel); end
      n_checks++; if (mem_err !== 1'b1) begin n_fail++; $display("FAIL rw_sticky got=%b exp=1", mem_err); end
      step(); rst = 1'b0; drive_nop(); #1;
      n_checks++; if ({ex_ctrl, mem_ctrl, wb_ctrl} !== 9'd0) begin n_fail++; $display("FAIL rw_bundles got=%b_%b_%b exp=0", ex_ctrl, mem_ctrl, wb_ctrl); end
      n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL rw_mem_err got=%b exp=0", mem_err); end
      n_checks++; if (pc_write !== 1'b1) begin n_fail++; $display("FAIL rw_run got=%b exp=1", pc_write); end
      mem_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_forward();
      test_branch();
      test_jump();
      test_mem_wait();
      test_timeout(16, 1'b0);
      test_timeout(17, 1'b1);
      test_reset_in_mwait();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
